// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of the shared 32-bit sll/sra shifter.
// One grant per cycle; the shifted, tagged result is held until it is consumed.
module shift_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  input  logic        req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [31:0] data_q, data_d;

  logic        can_accept;
  logic        gnt0, gnt1;
  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic        sel_op;

  function automatic logic [31:0] do_shift(input logic [31:0] d, input logic [4:0] s,
                                           input logic op);
    if (op) return 32'($signed(d) >>> s);
    else    return d << s;
  endfunction

  // Grants depend only on the valids, state, resp_ready and last_q, so the
  // two ready outputs never feed back into each other.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    can_accept = (state_q == EMPTY) || resp_ready;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (!reset && can_accept) begin
      if (req0_valid && req1_valid) begin
        if (FAIR && (last_q == 1'b0)) gnt1 = 1'b1;
        else                          gnt0 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = gnt1 ? req1_data  : req0_data;
    sel_shamt = gnt1 ? req1_shamt : req0_shamt;
    sel_op    = gnt1 ? req1_op    : req0_op;
  end

  // A grant while FULL and accepted replaces the result in one edge (back-to-back).
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    if (gnt0 || gnt1) begin
      state_d = FULL;
      last_d  = gnt1;
      id_d    = gnt1;
      data_d  = do_shift(sel_data, sel_shamt, sel_op);
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;
  assign resp_data  = data_q;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester arbiter and sequencer for the processor's shared 32-bit shifter (sll/sra). Two clients, the ALU issue port (requester 0) and the multdiv unit (requester 1), use valid/ready handshakes. The block picks one request per cycle, latches its operands, computes the shift through the combinational sll/sra datapath, and presents a registered, tagged result. The result is held until the consumer accepts it.

## Interface
- FAIR, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- clock  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- req0_data / req1_data  in  32  operand to shift
- req0_shamt / req1_shamt  in  5  shift amount 0–31
- req0_op / req1_op  in  1  0 = sll, 1 = sra
- resp_valid  out  1  result register holds an unconsumed result
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result
- resp_data  out  32  shifted result

## Operation
- States:
  - EMPTY: no result held.
  - FULL: result held; resp_valid = 1.
- Grant condition: `can_accept = (state == EMPTY) | resp_ready`.
  - At most one reqN_ready per cycle.
  - reqN_ready is asserted only when can_accept and reqN_valid.
- Arbitration with both valid:
  - FAIR = 1: grant the requester not granted last.
  - FAIR = 0: grant requester 0.
- With one valid, grant it regardless of FAIR.
- last_grant updates only on an actual grant.
- On grant at a clock edge:
  - resp_data ← shift(reqN_data, reqN_shamt, reqN_op).
  - resp_id ← N.
  - state ← FULL.
- sll: zero-fill from the LSB. sra: replicate bit 31. shamt = 0 passes data unchanged.
- Shift amounts ≥32 are impossible (5-bit port). No overflow flag.
- Transitions:
  - FULL with resp_ready and no grant → EMPTY.
  - FULL with resp_ready and a grant → FULL holding the new result (back-to-back).
  - FULL without resp_ready → hold resp_data and resp_id stable. No grants.
  - EMPTY with no valid → stay EMPTY.
- reqN_ready is combinational from the reqN_valid inputs, state, resp_ready and last_grant.
  - It must not depend on reqN_ready of the other port (no loops).
- Requesters may drop valid without a grant. The block has no obligation to remember ungranted requests.

## Timing
- Reset values:
  - state = EMPTY, resp_valid = 0, resp_id = 0, resp_data = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - req0_ready = req1_ready = 0 while reset is high.
- Latency: grant in cycle T → resp_valid = 1 in cycle T+1 with the result.
- Throughput: one result per cycle when resp_ready is held high.
- Fairness (FAIR = 1): a continuously valid requester is granted within 2 grants.
- Reset mid-operation:
  - A held result is discarded; resp_valid is 0 the cycle after reset.
  - A grant in the reset cycle is ignored.
- A simultaneous grant and accept in FULL is a single-edge update. No bubble, no duplicate response.
- Operands are sampled only at the grant edge; later changes on reqN_* do not affect the held result.

## Test plan
- Reset, then req0 only: req0_data = 0x0000_0001, shamt = 4, op = 0, resp_ready = 1 → req0_ready in T; T+1 resp_valid = 1, resp_id = 0, resp_data = 0x0000_0010. Idle next cycle → resp_valid = 0.
- sra sign fill on req1: data = 0x8000_0000, shamt = 31, op = 1 → resp_data = 0xFFFF_FFFF, resp_id = 1. Also shamt = 0, data = 0x1234_5678 → 0x1234_5678 unchanged.
- Contention, FAIR = 1, both valid for 4 cycles, resp_ready = 1 → grants 0,1,0,1 and resp_id sequence 0,1,0,1. FAIR = 0 → 0,0,0,0.
- Backpressure: resp_ready = 0 for 3 cycles with both valid → resp_data and resp_id stable, no reqN_ready. Raise resp_ready → same-cycle accept and new grant, next result the following cycle.
- Reset asserted while FULL and requests valid → next cycle resp_valid = 0, resp_data = 0. First grant after release goes to requester 0.
- Random sweep: 200 cycles of random valids, data, shamt, op and resp_ready. The scoreboard checks every response against data<<shamt or $signed(data)>>>shamt with a matching id, and checks no lost or duplicated grants.
